// File: rtl/mux_self_test_pkg.sv
// Shared types and constants for the mux self-test block.
package mux_self_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int NUM_VECTORS   = 8;
    localparam int IMPL_GATE     = 0;
    localparam int IMPL_DATAFLOW = 1;

    localparam logic [3:0] ERR_MAX = 4'd8;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v < ERR_MAX) ? v + 4'd1 : v;
    endfunction

endpackage

// File: rtl/mux_self_test_if.sv
// Control/status bundle of the mux self-test: start/inject in, stimulus pins and results out.
interface mux_self_test_if;

    logic       start;
    logic       inject;
    logic       a;
    logic       b;
    logic       sel;
    logic       out;
    logic [2:0] vec_idx;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;

    modport master (
        output start, inject,
        input  a, b, sel, out, vec_idx, busy, done, pass, err_count
    );

    modport slave (
        input  start, inject,
        output a, b, sel, out, vec_idx, busy, done, pass, err_count
    );

endinterface

// File: rtl/mux_self_test_mux2.sv
// 2:1 mux primitive under test; gate-level or dataflow form, purely combinational.
module mux2
    import mux_self_test_pkg::*;
#(
    parameter int IMPL = IMPL_GATE
) (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic out
);

    generate
        if (IMPL == IMPL_GATE) begin : g_gate
            assign out = (a & ~sel) | (b & sel);
        end else begin : g_dataflow
            assign out = sel ? b : a;
        end
    endgenerate

endmodule

// File: rtl/mux_self_test.sv
// Mux self-test: sweeps all {a,b,sel} vectors through mux2 and counts output mismatches.
//
// state   | meaning
// IDLE    | waiting for start, vec_idx parked at 0
// RUN     | applying vec_idx to the mux, compare on the last hold cycle
// DONE    | sweep finished, last vector held, pass/err_count valid
module mux_self_test
    import mux_self_test_pkg::*;
#(
    parameter int IMPL = IMPL_GATE,
    parameter int HOLD = 1
) (
    input  logic            clk,
    input  logic            rst,
    mux_self_test_if.slave  bus
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);
    localparam logic [2:0] VEC_LAST  = 3'(NUM_VECTORS - 1);

    state_t     state;
    logic [2:0] vec_idx;
    logic [7:0] hold_cnt;
    logic [3:0] err_count;
    logic       busy;
    logic       done;
    logic       pass;

    logic       a;
    logic       b;
    logic       sel;
    logic       mux_out;
    logic       expected;
    logic       mismatch;
    logic       last_hold;
    logic [3:0] err_next;

    // Stimulus bits come straight from the index: MSB drives a, LSB drives sel.
    assign {a, b, sel} = vec_idx;

    mux2 #(.IMPL(IMPL)) u_mux2 (
        .a   (a),
        .b   (b),
        .sel (sel),
        .out (mux_out)
    );

    assign expected  = sel ? b : a;
    assign mismatch  = (mux_out ^ bus.inject) != expected;
    assign last_hold = (hold_cnt == HOLD_LAST);
    assign err_next  = mismatch ? sat_inc(err_count) : err_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            vec_idx   <= 3'd0;
            hold_cnt  <= 8'd0;
            err_count <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state     <= ST_RUN;
                        vec_idx   <= 3'd0;
                        hold_cnt  <= 8'd0;
                        err_count <= 4'd0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (last_hold) begin
                        hold_cnt  <= 8'd0;
                        err_count <= err_next;
                        if (vec_idx == VEC_LAST) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == 4'd0);
                        end else begin
                            vec_idx <= vec_idx + 3'd1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a         = a;
    assign bus.b         = b;
    assign bus.sel       = sel;
    assign bus.out       = mux_out;
    assign bus.vec_idx   = vec_idx;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.pass      = pass;
    assign bus.err_count = err_count;

endmodule

// File: tb/tb_mux_self_test.sv
// Scoreboard bench for mux_self_test: gate and dataflow instances in lockstep plus a HOLD=3 instance.
module tb_mux_self_test;

    logic clk;
    logic rst;

    int checks;
    int errors;

    // Hand-computed mux output per vec_idx (bit i = out for vector i): 0,0,0,1,1,0,1,1
    logic [7:0] out_table;

    mux_self_test_if if0 ();
    mux_self_test_if if1 ();
    mux_self_test_if if3 ();

    mux_self_test #(.IMPL(0), .HOLD(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    mux_self_test #(.IMPL(1), .HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    mux_self_test #(.IMPL(0), .HOLD(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    // {vec_idx, out} per busy cycle, and {err_count, pass} per completed sweep
    logic [3:0] out_q[$];
    logic [4:0] res_q[$];
    logic [3:0] out3_q[$];
    logic [4:0] res3_q[$];

    logic done_prev0;
    logic done_prev3;
    int   busy_cnt3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
        return n;
    endfunction

    // Monitor: pops expectations whenever a DUT presents a vector or finishes a sweep.
    always begin
        logic [3:0] e;
        logic [4:0] r;
        @(negedge clk);
        if (if0.busy) begin
            if (out_q.size() == 0) begin
                chk("busy_without_vector", {7'd0, if0.busy}, 8'd0);
            end else begin
                e = out_q.pop_front();
                chk("vec_idx", {5'd0, if0.vec_idx}, {5'd0, e[3:1]});
                chk("stim_abc", {5'd0, if0.a, if0.b, if0.sel}, {5'd0, e[3:1]});
                chk("out_gate", {7'd0, if0.out}, {7'd0, e[0]});
                chk("out_dataflow", {7'd0, if1.out}, {7'd0, e[0]});
            end
        end
        if (if0.done && !done_prev0) begin
            if (res_q.size() == 0) begin
                chk("done_without_result", {7'd0, if0.done}, 8'd0);
            end else begin
                r = res_q.pop_front();
                chk("err_count_gate", {4'd0, if0.err_count}, {4'd0, r[4:1]});
                chk("pass_gate", {7'd0, if0.pass}, {7'd0, r[0]});
                chk("err_count_dataflow", {4'd0, if1.err_count}, {4'd0, r[4:1]});
                chk("pass_dataflow", {7'd0, if1.pass}, {7'd0, r[0]});
            end
        end
        done_prev0 = if0.done;

        if (if3.busy) begin
            busy_cnt3++;
            if (out3_q.size() == 0) begin
                chk("hold3_busy_without_vector", {7'd0, if3.busy}, 8'd0);
            end else begin
                e = out3_q.pop_front();
                chk("hold3_vec_idx", {5'd0, if3.vec_idx}, {5'd0, e[3:1]});
                chk("hold3_out", {7'd0, if3.out}, {7'd0, e[0]});
            end
        end
        if (if3.done && !done_prev3) begin
            if (res3_q.size() == 0) begin
                chk("hold3_done_without_result", {7'd0, if3.done}, 8'd0);
            end else begin
                r = res3_q.pop_front();
                chk("hold3_err_count", {4'd0, if3.err_count}, {4'd0, r[4:1]});
                chk("hold3_pass", {7'd0, if3.pass}, {7'd0, r[0]});
            end
        end
        done_prev3 = if3.done;
    end

    task automatic drive01(input logic s, input logic inj);
        if0.start  = s;
        if1.start  = s;
        if0.inject = inj;
        if1.inject = inj;
    endtask

    // HOLD=1 sweep on the lockstep pair; inject follows mask[v] on vector v's compare edge.
    task automatic sweep(input logic [7:0] mask);
        for (int v = 0; v < 8; v++) out_q.push_back({3'(v), out_table[v]});
        res_q.push_back({popcount8(mask), mask == 8'd0});
        @(posedge clk); #2;
        drive01(1'b1, 1'b0);
        @(posedge clk); #2;
        drive01(1'b0, 1'b0);
        for (int v = 0; v < 8; v++) begin
            drive01(1'b0, mask[v]);
            @(posedge clk); #2;
        end
        drive01(1'b0, 1'b0);
        chk("done_after_8", {7'd0, if0.done}, 8'd1);
        chk("busy_after_8", {7'd0, if0.busy}, 8'd0);
        chk("done_holds_last_vec", {5'd0, if0.a, if0.b, if0.sel}, 8'd7);
    endtask

    initial begin
        int c0;
        checks     = 0;
        errors     = 0;
        done_prev0 = 1'b0;
        done_prev3 = 1'b0;
        busy_cnt3  = 0;
        out_table  = 8'b1101_1000;
        drive01(1'b0, 1'b0);
        if3.start  = 1'b0;
        if3.inject = 1'b0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_pins", {1'b0, if0.a, if0.b, if0.sel, if0.out, if0.busy, if0.done, if0.pass}, 8'd0);
        chk("reset_vec_idx", {5'd0, if0.vec_idx}, 8'd0);
        chk("reset_err_count", {4'd0, if0.err_count}, 8'd0);
        chk("reset_pins_dataflow", {1'b0, if1.a, if1.b, if1.sel, if1.out, if1.busy, if1.done, if1.pass}, 8'd0);
        rst = 1'b0;

        sweep(8'h00);
        chk("pass_clean_sweep", {7'd0, if0.pass}, 8'd1);
        sweep(8'hFF);
        sweep(8'h00);
        sweep(8'b0000_1000);

        // Abort during vector 5 with an asynchronous reset
        for (int v = 0; v < 6; v++) out_q.push_back({3'(v), out_table[v]});
        @(posedge clk); #2;
        drive01(1'b1, 1'b0);
        @(posedge clk); #2;
        drive01(1'b0, 1'b0);
        repeat (5) begin
            @(posedge clk); #2;
        end
        chk("abort_at_vec5", {5'd0, if0.vec_idx}, 8'd5);
        #4;
        rst = 1'b1;
        #1;
        chk("abort_pins", {1'b0, if0.a, if0.b, if0.sel, if0.out, if0.busy, if0.done, if0.pass}, 8'd0);
        chk("abort_vec_idx", {5'd0, if0.vec_idx}, 8'd0);
        chk("abort_err_count", {4'd0, if0.err_count}, 8'd0);
        chk("abort_busy_dataflow", {7'd0, if1.busy}, 8'd0);
        #2;
        rst = 1'b0;
        sweep(8'h00);

        // HOLD=3: each vector presented for three busy cycles, 24 in total
        for (int v = 0; v < 8; v++)
            repeat (3) out3_q.push_back({3'(v), out_table[v]});
        res3_q.push_back({4'd0, 1'b1});
        c0 = busy_cnt3;
        @(posedge clk); #2;
        if3.start = 1'b1;
        @(posedge clk); #2;
        if3.start = 1'b0;
        for (int i = 0; i < 60 && !if3.done; i++) @(posedge clk);
        #2;
        chk("hold3_done", {7'd0, if3.done}, 8'd1);
        @(posedge clk); #2;
        chk("hold3_busy_cycles", 8'(busy_cnt3 - c0), 8'd24);

        repeat (2) @(posedge clk);
        chk("queue_drain_out", 8'(out_q.size()), 8'd0);
        chk("queue_drain_res", 8'(res_q.size()), 8'd0);
        chk("queue_drain_out3", 8'(out3_q.size()), 8'd0);
        chk("queue_drain_res3", 8'(res3_q.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_self_test.md
# mux_self_test

Self-checking 2:1 multiplexer block: a clocked stimulus sequencer drives every one of the 8 `{a,b,sel}` combinations into a 2:1 mux, and a checker compares each mux output against the expected value. It sits in the design as a power-on/bring-up sanity block for the mux primitive. It reports busy/done/pass and a mismatch count, and exposes the mux pins for waveform observation.

## Interface
- `IMPL`, default 0: mux implementation; 0 = gate-level (AND/OR/NOT), 1 = dataflow (conditional). Both must be functionally identical.
- `HOLD`, default 1: clock cycles each vector is held; legal range 1..255.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a sweep; sampled in IDLE or DONE.
- `inject`  in  1  fault injection; when 1, the checker sees the mux output inverted.
- `a`  out  1  mux data input 0 (stimulus).
- `b`  out  1  mux data input 1 (stimulus).
- `sel`  out  1  mux select (stimulus).
- `out`  out  1  mux output, combinational from `a`, `b`, `sel`.
- `vec_idx`  out  3  current vector index; `{a,b,sel}` = `vec_idx`.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  high in DONE when `err_count` == 0.
- `err_count`  out  4  mismatches in the current or last sweep; maximum 8.

## Operation
- Mux function: `out = sel ? b : a`.
  - Gate form: `(a & ~sel) | (b & sel)`.
  - No clock; `out` is always derived directly from `a`, `b`, `sel`.
- FSM states: IDLE, RUN, DONE.
  - IDLE: `vec_idx`=0. `start`=1 → RUN, with `err_count` cleared and `vec_idx`=0.
  - RUN: `vec_idx` drives `{a,b,sel}`, MSB = `a`, LSB = `sel`.
    - A hold counter runs 0..HOLD-1.
    - On the last hold cycle, the checker compares `out ^ inject` against the expected value `sel ? b : a`.
    - On a mismatch, `err_count` increments, saturating at 8.
    - Then `vec_idx` increments; if `vec_idx` was 7, go to DONE.
  - DONE: `a`/`b`/`sel` hold the last vector (all 1). `start`=1 → RUN, with a fresh sweep and `err_count` cleared.
- `start` during RUN is ignored.
- `inject` is sampled per compare and may change mid-sweep. Only the vectors whose compare cycle sees `inject`=1 count as errors.
- Vector order is fixed: 0,1,…,7.

Expected `out` per `vec_idx`:

| vec_idx | 0 | 1 | 2 | 3 | 4 | 5 | 6 | 7 |
|---|---|---|---|---|---|---|---|---|
| out | 0 | 0 | 0 | 1 | 1 | 0 | 1 | 1 |

## Timing
- Reset: state IDLE, `vec_idx`=0, `a`=`b`=`sel`=0, `out`=0, `busy`=`done`=`pass`=0, `err_count`=0, hold counter=0.
- Reset asserted mid-sweep aborts immediately (asynchronously) to the reset values.
- Start latency: `start` sampled high at edge N; `busy`=1 and vector 0 is applied after edge N.
- Sweep length: exactly 8·HOLD cycles in RUN.
- `done`=1 and `pass` valid from the edge that completes the vector-7 compare.
- `err_count` updates on the same edge as the compare.

## Structure
- Shared package `mux_self_test_pkg` holds:
  - the state enum (IDLE/RUN/DONE);
  - `NUM_VECTORS`=8;
  - the IMPL encodings `IMPL_GATE`=0 and `IMPL_DATAFLOW`=1.
- One sub-module, `mux2` (ports a, b, sel, out; parameter IMPL). It is purely combinational.
- The sequencer, FSM and checker live in `mux_self_test`.

## Test plan
- Reset, then `start` pulse, HOLD=1, `inject`=0: over 8 cycles `{a,b,sel}` steps 000…111.
  - `out` = 0,0,0,1,1,0,1,1.
  - `done`=1, `pass`=1, `err_count`=0 after the 8th cycle.
- `inject`=1 for the whole sweep: `err_count`=8, `pass`=0, `done`=1.
- `inject`=1 only during vector 3 (HOLD=1): `err_count`=1, `pass`=0.
- HOLD=3: each vector is held 3 cycles; `busy` lasts 24 cycles; `pass`=1.
- Assert `rst` during vector 5: all outputs return to reset values immediately. A new `start` completes a clean sweep with `pass`=1.
- Run the bench with IMPL=0 and IMPL=1 separately: each produces an identical `out` sequence; re-`start` from DONE clears `err_count`.
